// File: rtl/sample_ring_sram.sv
// -----------------------------------------------------------------------------
// sample_ring_sram
//
// Circular sample buffer that feeds the CIC interpolator upsampling stage.
// Samples are written into a DEPTH-word ring. An output stage pops them and
// presents each one as R output phases. The output can be plain FIFO (one
// phase), zero-stuffed (S, then R-1 zeros) or sample-and-hold (S for all R
// phases). The consumer side uses a valid/ready handshake.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   i_clear       : synchronous flush of pointers, count, phase, valid, overflow
//   i_write_EN    : write request for i_data (dropped while o_full)
//   i_data        : sample to store
//   o_full        : memory holds DEPTH words
//   o_empty       : memory holds no words
//   o_count       : words held in memory (the output stage is not counted)
//   o_overflow    : sticky flag, set when a write was dropped
//   i_mode        : 00/11 FIFO, 01 zero-stuff, 10 hold (latched per sample)
//   i_rate        : interpolation ratio R, 0 treated as 1 (latched per sample)
//   o_data        : output sample
//   o_valid       : o_data is valid
//   i_read_EN     : consumer ready; transfer when o_valid && i_read_EN
// -----------------------------------------------------------------------------
module sample_ring_sram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned RATE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_write_EN,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    input  logic [1:0]            i_mode,
    input  logic [RATE_WIDTH-1:0] i_rate,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_read_EN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_FIFO     = 2'b00,
        MODE_ZERO     = 2'b01,
        MODE_HOLD     = 2'b10,
        MODE_FIFO_ALT = 2'b11
    } mode_t;

    // Storage (not reset)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Ring state
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  overflow_q;

    // Output stage
    state_t                state_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] s_q;
    mode_t                 mode_q;
    logic [RATE_WIDTH-1:0] rate_q;
    logic [RATE_WIDTH-1:0] phase_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    // Handshake / control
    logic                  wr_acc;
    logic                  xfer;
    logic                  fifo_mode;
    logic                  last_phase;
    logic                  pop;
    logic [RATE_WIDTH-1:0] rate_eff;
    logic [DATA_WIDTH-1:0] rd_word;

    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign rd_word  = mem[rd_ptr_q];
    assign rate_eff = (i_rate == '0) ? RATE_WIDTH'(1) : i_rate;

    always_comb begin
        wr_acc     = i_write_EN && !full_q && !i_clear;
        xfer       = valid_q && i_read_EN;
        fifo_mode  = (mode_q == MODE_FIFO) || (mode_q == MODE_FIFO_ALT);
        // rate_q is never 0, so rate_q-1 cannot wrap even at the maximum R
        last_phase = fifo_mode || (phase_q == (rate_q - RATE_WIDTH'(1)));
        // The next word is read straight from the ring on the last-phase
        // transfer, so consecutive samples leave no gap on o_valid.
        pop        = !i_clear &&
                     (((state_q == ST_IDLE) && !empty_q) ||
                      ((state_q == ST_EMIT) && xfer && last_phase && !empty_q));

        wr_ptr_d = wr_acc ? ptr_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop    ? ptr_next(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (!wr_acc && pop) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end

        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            rd_data_q  <= '0;
            s_q        <= '0;
            mode_q     <= MODE_FIFO;
            rate_q     <= RATE_WIDTH'(1);
            phase_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == (ADDR_WIDTH+1)'(DEPTH));
            empty_q  <= (count_d == '0);

            if (i_clear) begin
                overflow_q <= 1'b0;
                state_q    <= ST_IDLE;
                phase_q    <= '0;
                valid_q    <= 1'b0;
            end else begin
                if (i_write_EN && full_q) begin
                    overflow_q <= 1'b1;
                end

                case (state_q)
                    ST_IDLE: begin
                        valid_q <= 1'b0;
                        if (!empty_q) begin
                            rd_data_q <= rd_word;
                            state_q   <= ST_LOAD;
                        end
                    end

                    ST_LOAD: begin
                        s_q     <= rd_data_q;
                        data_q  <= rd_data_q;
                        mode_q  <= mode_t'(i_mode);
                        rate_q  <= rate_eff;
                        phase_q <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_EMIT;
                    end

                    ST_EMIT: begin
                        if (xfer) begin
                            if (last_phase) begin
                                phase_q <= '0;
                                if (!empty_q) begin
                                    // Next sample goes straight to the output
                                    s_q    <= rd_word;
                                    data_q <= rd_word;
                                    mode_q <= mode_t'(i_mode);
                                    rate_q <= rate_eff;
                                end else begin
                                    valid_q <= 1'b0;
                                    state_q <= ST_IDLE;
                                end
                            end else begin
                                phase_q <= phase_q + RATE_WIDTH'(1);
                                data_q  <= (mode_q == MODE_ZERO) ? '0 : s_q;
                            end
                        end
                    end

                    default: begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_data     = data_q;
    assign o_valid    = valid_q;

endmodule

// File: tb/tb_sample_ring_sram.sv
module tb_sample_ring_sram;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned DP = 4;
    localparam int unsigned RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_clear = 1'b0;
    logic          i_write_EN = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_full;
    logic          o_empty;
    logic [AW:0]   o_count;
    logic          o_overflow;
    logic [1:0]    i_mode = 2'b00;
    logic [RW-1:0] i_rate = 8'd1;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_read_EN = 1'b0;

    sample_ring_sram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DP),
        .RATE_WIDTH(RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (i_clear),
        .i_write_EN(i_write_EN),
        .i_data    (i_data),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_count   (o_count),
        .o_overflow(o_overflow),
        .i_mode    (i_mode),
        .i_rate    (i_rate),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_read_EN (i_read_EN)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    int unsigned   cyc = 0;
    int unsigned   bubbles = 0;
    bit            armed = 0;
    bit            seen_valid = 0;
    int unsigned   valid_cyc = 0;
    int unsigned   first_wr_edge = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: a transfer happens on the next edge
    always @(negedge clk) begin
        if (!rst && o_valid && i_read_EN) begin
            check("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("out_data", o_data, exp_q.pop_front());
            armed = 1;
        end
        if (!rst && !o_valid && exp_q.size() != 0 && armed) bubbles++;
        if (exp_q.size() == 0) armed = 0;
        if (o_valid && !seen_valid) begin
            seen_valid = 1;
            valid_cyc  = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [DW-1:0] v);
        int unsigned rr;
        rr = (i_rate == 0) ? 1 : int'(i_rate);
        if (i_mode == 2'b00 || i_mode == 2'b11) exp_q.push_back(v);
        else for (int unsigned k = 0; k < rr; k++)
            exp_q.push_back((i_mode == 2'b01 && k != 0) ? '0 : v);
    endtask

    task automatic wr(input logic [DW-1:0] v, input bit expect_store);
        i_write_EN = 1'b1;
        i_data     = v;
        if (expect_store) push_sample(v);
        step();
        i_write_EN = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", (exp_q.size() == 0 && !o_valid), 1'b1);
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (!o_valid && n < budget) begin
            step();
            n++;
        end
        check("valid_seen", o_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nxt;
        int unsigned n;

        // Reset state
        #12;
        check("rst_data", o_data, 0);
        check("rst_valid", o_valid, 0);
        check("rst_full", o_full, 0);
        check("rst_empty", o_empty, 1);
        check("rst_count", o_count, 0);
        check("rst_ovf", o_overflow, 0);
        #1 rst = 1'b0;
        step();

        // 1: FIFO, latency and order
        i_mode = 2'b00; i_rate = 8'd1; i_read_EN = 1'b1;
        bubbles = 0; seen_valid = 0;
        first_wr_edge = cyc + 1;
        wr(32'd1, 1); wr(32'd2, 1); wr(32'd3, 1); wr(32'd4, 1);
        wait_drain(30);
        check("t1_latency", valid_cyc, first_wr_edge + 2);
        check("t1_bubbles", bubbles, 0);
        check("t1_empty", o_empty, 1);
        check("t1_valid", o_valid, 0);

        // 2: hold R=3, zero-stuff R=4, R=0, R=255
        i_mode = 2'b10; i_rate = 8'd3; bubbles = 0;
        wr(32'd5, 1); wr(32'd7, 1);
        wait_drain(30);
        check("t2_hold_bubbles", bubbles, 0);
        i_mode = 2'b01; i_rate = 8'd4;
        wr(32'd9, 1);
        wait_drain(30);
        i_mode = 2'b10; i_rate = 8'd0;
        wr(32'd3, 1); wr(32'd33, 1);
        wait_drain(30);
        i_mode = 2'b01; i_rate = 8'd255;
        wr(32'hAB, 1);
        wait_drain(300);

        // 3: fill to full, overflow, drain
        i_mode = 2'b00; i_rate = 8'd1; i_read_EN = 1'b0;
        for (int unsigned v = 10; v <= 14; v++) wr(v, 1);
        wr(32'd15, 0);
        check("t3_full", o_full, 1);
        check("t3_count", o_count, 4);
        check("t3_ovf", o_overflow, 1);
        i_read_EN = 1'b1;
        wait_drain(30);
        check("t3_ovf_sticky", o_overflow, 1);
        i_clear = 1'b1; step(); i_clear = 1'b0;
        check("t3_ovf_cleared", o_overflow, 0);

        // 4: backpressure at p=1 in hold mode
        i_mode = 2'b10; i_rate = 8'd2; i_read_EN = 1'b0;
        wr(32'd6, 1);
        wait_valid(10);
        i_read_EN = 1'b1;
        step();
        i_read_EN = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            step();
            check("t4_hold_valid", o_valid, 1);
            check("t4_hold_data", o_data, 32'd6);
        end
        i_read_EN = 1'b1;
        wait_drain(20);
        step(); step();
        check("t4_no_extra", o_valid, 0);

        // 5: wrap-around with random consumer
        i_mode = 2'b00; i_rate = 8'd1;
        nxt = 0; n = 0;
        while (nxt < 10 && n < 300) begin
            i_read_EN = 1'($urandom_range(0, 1));
            if (!o_full) begin
                i_write_EN = 1'b1;
                i_data = nxt;
                push_sample(nxt);
                nxt++;
            end else begin
                i_write_EN = 1'b0;
            end
            step();
            n++;
        end
        i_write_EN = 1'b0;
        i_read_EN = 1'b1;
        wait_drain(50);
        check("t5_all_written", nxt, 10);
        check("t5_no_ovf", o_overflow, 0);

        // 6: async reset mid-EMIT
        i_mode = 2'b10; i_rate = 8'd3; i_read_EN = 1'b1;
        wr(32'd8, 1);
        wait_valid(10);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_valid", o_valid, 0);
        check("t6_rst_data", o_data, 0);
        check("t6_rst_empty", o_empty, 1);
        check("t6_rst_count", o_count, 0);
        check("t6_rst_full", o_full, 0);
        #1 rst = 1'b0;
        exp_q.delete();
        armed = 0;
        step();

        // 6b: clear with three words held
        i_mode = 2'b00; i_rate = 8'd1; i_read_EN = 1'b0;
        wr(32'd20, 1); wr(32'd21, 1); wr(32'd22, 1); wr(32'd23, 1);
        check("t6_held_count", o_count, 3);
        i_clear = 1'b1; step(); i_clear = 1'b0;
        exp_q.delete();
        check("t6_clr_count", o_count, 0);
        check("t6_clr_empty", o_empty, 1);
        check("t6_clr_valid", o_valid, 0);
        step(); step();
        check("t6_clr_stays_idle", o_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_ring_sram.md
Name: sample_ring_sram

Overview:
Parametrised circular sample buffer for the CIC interpolator datapath. It replaces the fixed write-only SRAM with a ring buffer that has independent write and read pointers, full/empty/count status and a valid/ready output stage. The output stage can re-emit each stored sample R times, either as zero-stuffed or sample-and-hold, so the buffer feeds the interpolator's upsampling stage directly.

Parameters:
DATA_WIDTH, 32, sample width in bits
ADDR_WIDTH, 8, pointer width; DEPTH <= 2**ADDR_WIDTH
DEPTH, 256, number of storage words; must be >= 2; need not be a power of two
RATE_WIDTH, 8, width of the interpolation-ratio input

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
i_clear  in  1  synchronous flush
i_write_EN  in  1  write request
i_data  in  DATA_WIDTH  sample to write
o_full  out  1  high when the buffer holds DEPTH words
o_empty  out  1  high when the buffer holds 0 words
o_count  out  ADDR_WIDTH+1  words held in memory, excluding the output stage
o_overflow  out  1  sticky flag: a write was dropped
i_mode  in  2  00 = FIFO, 01 = zero-stuff, 10 = hold, 11 = FIFO
i_rate  in  RATE_WIDTH  interpolation ratio R; 0 is treated as 1
o_data  out  DATA_WIDTH  output sample
o_valid  out  1  o_data is valid
i_read_EN  in  1  consumer ready; a transfer occurs when o_valid && i_read_EN

Behaviour:
- Reset values: o_data=0, o_valid=0, o_full=0, o_empty=1, o_count=0, o_overflow=0. Pointers and the phase counter are 0, and the FSM is in IDLE. Memory contents are not reset.
- rst asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Writes:
  - A write is accepted when i_write_EN && !o_full: mem[wr_ptr] <= i_data, and wr_ptr advances.
  - The write pointer wraps from DEPTH-1 to 0. The read pointer wraps the same way.
  - A write while o_full is dropped and sets o_overflow. o_overflow stays set until rst or i_clear.
- Flag timing:
  - o_full, o_empty and o_count are registered and derived from count, not from pointer comparison.
  - A pop while full does not admit a write in the same cycle; that write is dropped and sets overflow.
  - A simultaneous write and pop on a non-full, non-empty buffer leaves count unchanged.
- FSM states:
  - IDLE: o_valid=0. If !o_empty, issue a memory read at rd_ptr, advance rd_ptr, decrement count, go to LOAD.
  - LOAD: the read data registers into the sample register S. Latch mode M=i_mode and ratio R=max(i_rate,1). Set phase p=0 and o_valid=1, then go to EMIT.
  - EMIT: on each transfer, p increments. When a transfer occurs at p==R-1 (always, in FIFO mode):
    - if !o_empty, prefetch the next word so the next sample is presented on the following cycle with o_valid held at 1 (no bubble);
    - otherwise o_valid drops to 0 and the FSM returns to IDLE.
    - The prefetch read is issued in the cycle before the last-phase transfer, or an equivalent scheme is used, so back-to-back samples never insert an idle cycle.
- Output data per mode:
  - FIFO: o_data = S, emitted once.
  - Zero-stuff: o_data = S at p=0, and 0 for p=1..R-1.
  - Hold: o_data = S for all R phases.
- Latency: with the buffer empty and the FSM in IDLE, a sample written at edge N appears with o_valid=1 after edge N+2.
- Backpressure: while o_valid && !i_read_EN, o_data, p and S are held stable.
- Mode and rate latching: i_mode and i_rate are latched per sample at load. Changes during EMIT take effect on the next sample only.
- i_clear: sets count=0, both pointers=0, p=0, o_valid=0, o_overflow=0 and the FSM to IDLE. A write or transfer in the same cycle is ignored.
- Arithmetic: count is ADDR_WIDTH+1 bits. The phase counter is RATE_WIDTH bits, and R=2**RATE_WIDTH-1 must work without wrap errors.

Test Plan:
1. Reset; FIFO mode; write 1,2,3,4 on consecutive edges; i_read_EN=1 -> o_data 1,2,3,4 on four consecutive valid cycles; first o_valid two edges after the first write; then o_valid=0 and o_empty=1.
2. Hold mode, i_rate=3; write 5,7 -> o_data 5,5,5,7,7,7 with no bubble between samples. Zero-stuff mode, i_rate=4; write 9 -> 9,0,0,0. i_rate=0 -> identical to R=1.
3. DEPTH=4, i_read_EN=0; write 10..15:
   - the first word moves to the output stage, then 4 more words fill the buffer: o_full=1, o_count=4;
   - the 6th write is dropped and o_overflow=1;
   - draining yields 10,11,12,13,14.
4. Backpressure: hold mode, R=2, sample 6; i_read_EN low for 5 cycles at p=1 -> o_data=6 and o_valid=1 stay stable; only one more 6 is emitted after release.
5. Wrap-around: DEPTH=4, stream 0..9 continuously in FIFO mode with random i_read_EN -> output order 0..9 preserved, no overflow.
6. Async rst pulse between clock edges mid-EMIT -> all outputs at reset values before the next edge. i_clear with 3 words held -> o_count=0, o_empty=1, o_valid=0 the following cycle.
